nibble_serial_add: RTL

Multi-cycle W-bit adder/subtractor that sits directly around the team's 4-bit carry-lookahead stage. It latches two wide operands and feeds them one nibble per cycle, LSB first, through a single 4-bit CLA datapath (generate/propagate with internal lookahead carries C1..C4). It registers each nibble sum and chains the group carry-out back in as the next carry-in. On completion it reports the full sum plus carry, signed-overflow and zero flags with a done pulse.

---
 rtl/nibble_serial_add.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/nibble_serial_add.sv
// Serial W-bit adder/subtractor: one nibble per cycle through a single 4-bit
// carry-lookahead stage, LSB first, with the group carry chained between cycles.

module nibble_cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] sum,
   output logic       c3,
   output logic       c4
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;
   logic       gg;
   logic       pg;

   // Lookahead carries are flattened sums of products so no carry ripples inside the nibble
   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      pg   = &p;
      c4   = gg | (pg & ci);
      c3   = c[3];
      sum  = p ^ c;
   end

endmodule

module nibble_serial_add #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sub,
   input  logic                 Cin,
   input  logic [4*NIBBLES-1:0] A,
   input  logic [4*NIBBLES-1:0] B,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] S,
   output logic                 Cout,
   output logic                 V,
   output logic                 Z
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   state_t        nstate;
   logic [W-1:0]  areg;
   logic [W-1:0]  breg;
   logic          carry;
   logic [IW-1:0] idx;
   logic [3:0]    anib;
   logic [3:0]    bnib;
   logic [3:0]    sum;
   logic          c3;
   logic          c4;
   logic [W-1:0]  snext;
   logic          last;
   logic          accept;
   int            base;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   // start is honoured in IDLE and DONE only, so a request during RUN is dropped
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (start) nstate = RUN;
         RUN:     if (last) nstate = DONE;
         DONE:    nstate = start ? RUN : IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      last   = (idx == LAST);
      accept = start && (state != RUN);
      busy   = (state == RUN);
      done   = (state == DONE);
   end

   // Current nibble is selected from the latched operands; snext is the word after this write
   always_comb begin
      base          = int'(idx) * 4;
      anib          = areg[base +: 4];
      bnib          = breg[base +: 4];
      snext         = S;
      snext[base +: 4] = sum;
   end

   nibble_cla4 u_cla (
      .a   (anib),
      .b   (bnib),
      .ci  (carry),
      .sum (sum),
      .c3  (c3),
      .c4  (c4)
   );

   // Subtraction is A + ~B + 1, so Cout reads as "no borrow"
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         areg  <= '0;
         breg  <= '0;
         carry <= 1'b0;
         idx   <= '0;
         S     <= '0;
         Cout  <= 1'b0;
         V     <= 1'b0;
         Z     <= 1'b0;
      end else if (accept) begin
         areg  <= A;
         breg  <= sub ? ~B : B;
         carry <= sub | Cin;
         idx   <= '0;
         S     <= '0;
         Cout  <= 1'b0;
         V     <= 1'b0;
         Z     <= 1'b0;
      end else if (state == RUN) begin
         S     <= snext;
         carry <= c4;
         idx   <= last ? '0 : idx + 1'b1;
         if (last) begin
            Cout <= c4;
            V    <= c3 ^ c4;
            Z    <= (snext == '0);
         end
      end
   end

endmodule
